vga_pixel_fetch: RTL and testbench

//  Pixel source directly downstream of vga_control. Consumes h_count/v_count/bright/h_sync/v_sync,

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_line_buffer.sv | 31 +++
 rtl/vga_pixel_fetch.sv | 182 ++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry, RGB332 field widths and the
// line-fill state encoding for the VGA pixel path.
package vga_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int COUNTER_BITS = 16;
  localparam int SCALE_SHIFT  = 2;
  localparam int FB_W         = H_RES >> SCALE_SHIFT;
  localparam int FB_H         = V_RES >> SCALE_SHIFT;
  localparam int ADDR_BITS    = 16;
  localparam int PIX_BITS     = 8;
  localparam int R_BITS       = 3;
  localparam int G_BITS       = 3;
  localparam int B_BITS       = 2;
  localparam int COL_BITS     = 8;
  localparam int ROW_BITS     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_e;

  // First video RAM address of a framebuffer row in the selected framebuffer.
  function automatic logic [ADDR_BITS-1:0] row_base(input logic fb,
                                                    input logic [ROW_BITS-1:0] row);
    logic [ADDR_BITS-1:0] frame;
    if (fb) begin
      frame = ADDR_BITS'(FB_W * FB_H);
    end else begin
      frame = '0;
    end
    return frame + ADDR_BITS'(row) * ADDR_BITS'(FB_W);
  endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// One framebuffer row of pixels: synchronous write, asynchronous read, no reset.
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [COL_BITS-1:0] waddr_i,
  input  logic [PIX_BITS-1:0] wdata_i,
  input  logic [COL_BITS-1:0] raddr_i,
  output logic [PIX_BITS-1:0] rdata_o
);

  logic [PIX_BITS-1:0] mem_q [FB_W];

  // Store returned video RAM bytes
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < COL_BITS'(FB_W))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Columns past the row width read as black
  always_comb begin
    if (raddr_i < COL_BITS'(FB_W)) begin
      rdata_o = mem_q[raddr_i];
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Prefetches one framebuffer row into a line buffer during horizontal blanking
// and drives 4x-upscaled RGB332 colour plus re-registered syncs.
module vga_pixel_fetch
  import vga_pkg::*;
(
  input  logic                    clk_50MHz,
  input  logic                    clear,
  input  logic [COUNTER_BITS-1:0] h_count,
  input  logic [COUNTER_BITS-1:0] v_count,
  input  logic                    bright,
  input  logic                    h_sync,
  input  logic                    v_sync,
  input  logic                    fb_sel,
  output logic                    vram_rd,
  output logic [ADDR_BITS-1:0]    vram_addr,
  input  logic [PIX_BITS-1:0]     vram_rdata,
  output logic [R_BITS-1:0]       vga_r,
  output logic [G_BITS-1:0]       vga_g,
  output logic [B_BITS-1:0]       vga_b,
  output logic                    hs_out,
  output logic                    vs_out,
  output logic                    fill_busy,
  output logic                    fill_ovr
);

  fill_state_e          state_q, state_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q;
  logic                 pend_q;
  logic [COL_BITS-1:0]  wcol_q;
  logic                 trig_hold_q;
  logic                 fb_sel_q;
  logic [PIX_BITS-1:0]  rgb_q, rgb_d;
  logic                 hs_q, vs_q;

  logic                 trig_lvl_s;
  logic                 trig_s;
  logic [ROW_BITS-1:0]  row_s;
  logic [COL_BITS-1:0]  rd_idx_s;
  logic [PIX_BITS-1:0]  lb_rdata_s;

  // Fill request level and target row from the counter position
  always_comb begin
    trig_lvl_s = 1'b0;
    row_s      = '0;
    if (h_count == COUNTER_BITS'(H_RES)) begin
      if (v_count == COUNTER_BITS'(V_RES)) begin
        trig_lvl_s = 1'b1;
        row_s      = '0;
      end else if ((v_count < COUNTER_BITS'(V_RES - 1)) && (v_count[1:0] == 2'b11)) begin
        trig_lvl_s = 1'b1;
        row_s      = ROW_BITS'((v_count + COUNTER_BITS'(1)) >> SCALE_SHIFT);
      end else begin
        trig_lvl_s = 1'b0;
      end
    end else begin
      trig_lvl_s = 1'b0;
    end
  end

  // Counters hold for several clocks, so only the first clock of a match fires
  assign trig_s = trig_lvl_s & ~trig_hold_q;

  // Fill FSM next state, request address and overrun flag
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d = ST_FILL;
          col_d   = '0;
          addr_d  = row_base(fb_sel_q, row_s);
          rd_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (trig_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
        if (col_q == COL_BITS'(FB_W - 1)) begin
          state_d = ST_DRAIN;
          rd_d    = 1'b0;
        end else begin
          col_d  = col_q + COL_BITS'(1);
          addr_d = addr_q + ADDR_BITS'(1);
          rd_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (trig_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_idx_s = COL_BITS'(h_count >> SCALE_SHIFT);

  // Blanked pixels are forced to black
  always_comb begin
    if (bright) begin
      rgb_d = lb_rdata_s;
    end else begin
      rgb_d = '0;
    end
  end

  // State, fill bookkeeping and output registers
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      wcol_q      <= '0;
      trig_hold_q <= 1'b0;
      fb_sel_q    <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      ovr_q       <= ovr_d;
      busy_q      <= (state_d != ST_IDLE);
      // Byte for the request issued this clock arrives next clock
      pend_q      <= rd_q;
      wcol_q      <= col_q;
      trig_hold_q <= trig_lvl_s;
      if ((v_count == COUNTER_BITS'(V_RES)) && (h_count == COUNTER_BITS'(0))) begin
        fb_sel_q <= fb_sel;
      end else begin
        fb_sel_q <= fb_sel_q;
      end
      rgb_q       <= rgb_d;
      hs_q        <= h_sync;
      vs_q        <= v_sync;
    end
  end

  vga_line_buffer u_line_buffer (
    .clk_i   (clk_50MHz),
    .we_i    (pend_q),
    .waddr_i (wcol_q),
    .wdata_i (vram_rdata),
    .raddr_i (rd_idx_s),
    .rdata_o (lb_rdata_s)
  );

  assign vram_rd   = rd_q;
  assign vram_addr = addr_q;
  assign vga_r     = rgb_q[PIX_BITS-1 -: R_BITS];
  assign vga_g     = rgb_q[B_BITS +: G_BITS];
  assign vga_b     = rgb_q[B_BITS-1:0];
  assign hs_out    = hs_q;
  assign vs_out    = vs_q;
  assign fill_busy = busy_q;
  assign fill_ovr  = ovr_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized self-checking bench for vga_pixel_fetch against a row/pixel
// reference model built from framebuffer geometry and a keyed VRAM pattern.
module tb_vga_pixel_fetch;

  logic        clk;
  logic        clear;
  logic [15:0] h_cnt, v_cnt;
  logic        bright, hs_in, vs_in, fb_sel;
  logic        vram_rd;
  logic [15:0] vram_addr;
  logic [7:0]  vram_rdata;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        hs_out, vs_out, fill_busy, fill_ovr;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  key   = 8'h00;
  logic        fb_model = 1'b0;
  logic [7:0]  ref_lb [160];
  logic [15:0] rd_log [$];
  int          busy_cnt = 0;

  vga_pixel_fetch dut (
    .clk_50MHz (clk),
    .clear     (clear),
    .h_count   (h_cnt),
    .v_count   (v_cnt),
    .bright    (bright),
    .h_sync    (hs_in),
    .v_sync    (vs_in),
    .fb_sel    (fb_sel),
    .vram_rd   (vram_rd),
    .vram_addr (vram_addr),
    .vram_rdata(vram_rdata),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .fill_busy (fill_busy),
    .fill_ovr  (fill_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM: data one clock after the strobe, junk otherwise
  always @(posedge clk) begin
    if (vram_rd) vram_rdata <= vram_addr[7:0] ^ key;
    else         vram_rdata <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (vram_rd === 1'b1) rd_log.push_back(vram_addr);
    if (fill_busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch_fb(input logic val);
    v_cnt = 16'd480; h_cnt = 16'd0; fb_sel = val;
    tick(); tick();
    fb_model = val;
    h_cnt = 16'd1;
    tick();
    fb_sel = 1'($urandom);
  endtask

  task automatic run_fill(input int v, input int row, input bit retrig, input logic exp_ovr);
    int   base;
    int   miss;
    logic [15:0] a;
    base = (fb_model ? 19200 : 0) + row * 160;
    rd_log.delete();
    busy_cnt = 0;
    bright = 1'b0;
    v_cnt = 16'(v); h_cnt = 16'd640;
    tick(); tick();
    h_cnt = 16'd641;
    if (retrig) begin
      for (int k = 0; k < 20; k++) tick();
      h_cnt = 16'd640;
      tick(); tick();
      h_cnt = 16'd641;
    end
    for (int k = 0; k < 200; k++) tick();
    check("rd_count", rd_log.size(), 160);
    miss = 0;
    foreach (rd_log[i]) if (rd_log[i] != 16'(base + i)) miss++;
    check("addr_seq", miss, 0);
    check("busy_clks", busy_cnt, 161);
    check("ovr", fill_ovr, exp_ovr);
    for (int i = 0; i < 160; i++) begin
      a = 16'(base + i);
      ref_lb[i] = a[7:0] ^ key;
    end
  endtask

  task automatic pixel(input int v, input int h, input logic br);
    logic [7:0] exp;
    v_cnt = 16'(v); h_cnt = 16'(h); bright = br;
    hs_in = 1'($urandom); vs_in = 1'($urandom);
    tick();
    exp = br ? ref_lb[h >> 2] : 8'h00;
    check("rgb", {vga_r, vga_g, vga_b}, exp);
    check("hs", hs_out, hs_in);
    check("vs", vs_out, vs_in);
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pixel($urandom_range(478, 0), $urandom_range(639, 0), 1'($urandom));
    end
  endtask

  task automatic pulse_reset();
    #2 clear = 1'b0;
    #1;
    check("rst_rgb", {vga_r, vga_g, vga_b}, 8'h00);
    check("rst_hs", hs_out, 1'b1);
    check("rst_vs", vs_out, 1'b1);
    check("rst_rd", vram_rd, 1'b0);
    check("rst_busy", fill_busy, 1'b0);
    check("rst_ovr", fill_ovr, 1'b0);
    h_cnt = 16'd0;
    tick();
    clear = 1'b1;
    fb_model = 1'b0;
    tick();
  endtask

  initial begin
    clear = 1'b1; h_cnt = 16'd0; v_cnt = 16'd0; bright = 1'b0;
    hs_in = 1'b0; vs_in = 1'b0; fb_sel = 1'b0;
    #2 clear = 1'b0;
    #1;
    check("init_hs", hs_out, 1'b1);
    check("init_vs", vs_out, 1'b1);
    check("init_rd", vram_rd, 1'b0);
    check("init_busy", fill_busy, 1'b0);
    tick();
    clear = 1'b1;
    tick();
    check("hs_follow", hs_out, 1'b0);

    // Row 0 of framebuffer 0 with byte = addr[7:0]
    latch_fb(1'b0);
    key = 8'h00;
    run_fill(480, 0, 0, 1'b0);
    pixel(0, 8, 1'b1);
    check("pix_v0_h8", {vga_r, vga_g, vga_b}, 8'h02);
    pixel(0, 8, 1'b0);
    pixel(0, 639, 1'b1);
    check("pix_h639", {vga_r, vga_g, vga_b}, 8'h9F);
    rand_pixels(30);

    // Mid-frame reset while colour is non-zero
    pixel(0, 8, 1'b1);
    pulse_reset();

    // Second framebuffer, row 2
    latch_fb(1'b1);
    key = 8'($urandom);
    run_fill(7, 2, 0, 1'b0);
    if (rd_log.size() == 160) begin
      check("first_addr", rd_log[0], 16'd19520);
      check("last_addr", rd_log[159], 16'd19679);
    end
    rand_pixels(30);

    // Last visible line never triggers a fill
    rd_log.delete(); busy_cnt = 0;
    v_cnt = 16'd479; h_cnt = 16'd640; bright = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    h_cnt = 16'd641;
    tick();
    check("no_fill_479", rd_log.size(), 0);
    check("no_busy_479", busy_cnt, 0);

    // fb_sel input changes away from the latch point are ignored
    fb_sel = 1'b0;
    key = 8'($urandom);
    run_fill(3, 1, 0, 1'b0);
    rand_pixels(20);

    // Overrun: retrigger during a fill, flag is sticky
    key = 8'($urandom);
    run_fill(11, 3, 1, 1'b1);
    key = 8'($urandom);
    run_fill(15, 4, 0, 1'b1);
    rand_pixels(20);

    // Reset in the middle of a fill, then a clean refill from column 0
    rd_log.delete();
    v_cnt = 16'd23; h_cnt = 16'd640; bright = 1'b0;
    tick(); tick();
    h_cnt = 16'd641;
    for (int k = 0; k < 300 && rd_log.size() < 50; k++) tick();
    check("mid_fill_reached", rd_log.size() >= 50, 1'b1);
    pulse_reset();
    key = 8'($urandom);
    run_fill(23, 6, 0, 1'b0);
    if (rd_log.size() == 160) check("restart_addr", rd_log[0], 16'd960);
    rand_pixels(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
